// File: rtl/lsu_mem_master.sv
// lsu_mem_master: load/store initiator for the core's data-memory port.
// It turns RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW requests into word-wide memory
// accesses. Sub-word stores are done as read-modify-write. Load data is
// lane-extracted and then sign- or zero-extended.
// Ports:
//   CLK, RST          clock, synchronous active-high reset
//   req_valid/ready   request handshake; ready only in IDLE
//   req_store         1 = store, 0 = load
//   req_funct3        RISC-V access size/sign code
//   req_addr          byte address
//   req_wdata         store data, right-aligned
//   resp_valid        one-cycle completion pulse
//   resp_rdata        extended load data (0 for stores and errors)
//   resp_err          misaligned or illegal funct3, qualified by resp_valid
//   mem_a             word-aligned memory address
//   mem_wd            memory write data
//   mem_we            memory write enable
//   mem_rd            registered memory read data
module lsu_mem_master #(
    parameter int unsigned A_WIDTH = 32,
    parameter int unsigned D_WIDTH = 32
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_store,
    input  logic [2:0]         req_funct3,
    input  logic [A_WIDTH-1:0] req_addr,
    input  logic [D_WIDTH-1:0] req_wdata,
    output logic               resp_valid,
    output logic [D_WIDTH-1:0] resp_rdata,
    output logic               resp_err,
    output logic [A_WIDTH-1:0] mem_a,
    output logic [D_WIDTH-1:0] mem_wd,
    output logic               mem_we,
    input  logic [D_WIDTH-1:0] mem_rd
);

    localparam int unsigned F3_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LD_WAIT,
        ST_RMW_MERGE,
        ST_WRITE,
        ST_ERR
    } state_t;

    state_t             state_q, state_d;
    logic [A_WIDTH-1:0] addr_q, addr_d;
    logic [F3_W-1:0]    f3_q, f3_d;
    logic               store_q, store_d;
    logic [D_WIDTH-1:0] wdata_q, wdata_d;
    logic [D_WIDTH-1:0] wd_q, wd_d;
    logic               resp_valid_d, resp_err_d;
    logic [D_WIDTH-1:0] resp_rdata_d;

    logic               req_legal;
    logic [7:0]         ld_byte;
    logic [15:0]        ld_half;
    logic [D_WIDTH-1:0] ld_ext;
    logic [D_WIDTH-1:0] merged;

    // Legality and alignment of the incoming request
    always_comb begin
        req_legal = 1'b0;
        case (req_funct3)
            3'b000:  req_legal = 1'b1;
            3'b001:  req_legal = !req_addr[0];
            3'b010:  req_legal = (req_addr[1:0] == 2'b00);
            3'b100:  req_legal = !req_store;
            3'b101:  req_legal = !req_store && !req_addr[0];
            default: req_legal = 1'b0;
        endcase
    end

    // Little-endian lane extraction and extension of load data
    always_comb begin
        ld_byte = mem_rd[{addr_q[1:0], 3'b000} +: 8];
        ld_half = addr_q[1] ? mem_rd[31:16] : mem_rd[15:0];
        case (f3_q)
            3'b000:  ld_ext = {{(D_WIDTH-8){ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext = {{(D_WIDTH-16){ld_half[15]}}, ld_half};
            3'b100:  ld_ext = {{(D_WIDTH-8){1'b0}}, ld_byte};
            3'b101:  ld_ext = {{(D_WIDTH-16){1'b0}}, ld_half};
            default: ld_ext = mem_rd;
        endcase
    end

    // Replace the addressed byte/half of the fetched word with store data
    always_comb begin
        merged = mem_rd;
        case (f3_q[1:0])
            2'b00:   merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            2'b01:   merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            default: merged = wdata_q;
        endcase
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        f3_d         = f3_q;
        store_d      = store_q;
        wdata_d      = wdata_q;
        wd_d         = wd_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = '0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    f3_d    = req_funct3;
                    store_d = req_store;
                    wdata_d = req_wdata;
                    wd_d    = req_wdata;
                    if (!req_legal)          state_d = ST_ERR;
                    else if (!req_store)     state_d = ST_LD_WAIT;
                    else if (req_funct3[1])  state_d = ST_WRITE;
                    else                     state_d = ST_RMW_MERGE;
                end
            end
            ST_LD_WAIT: begin
                resp_valid_d = 1'b1;
                resp_rdata_d = store_q ? '0 : ld_ext;
                state_d      = ST_IDLE;
            end
            ST_RMW_MERGE: begin
                wd_d    = merged;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                resp_valid_d = 1'b1;
                state_d      = ST_IDLE;
            end
            ST_ERR: begin
                resp_valid_d = 1'b1;
                resp_err_d   = 1'b1;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and request registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            f3_q       <= '0;
            store_q    <= 1'b0;
            wdata_q    <= '0;
            wd_q       <= '0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            f3_q       <= f3_d;
            store_q    <= store_d;
            wdata_q    <= wdata_d;
            wd_q       <= wd_d;
            resp_valid <= resp_valid_d;
            resp_err   <= resp_err_d;
            resp_rdata <= resp_rdata_d;
        end
    end

    // The memory samples the request's word address at the accept edge
    assign req_ready = (state_q == ST_IDLE);
    assign mem_a     = (state_q == ST_IDLE) ? {req_addr[A_WIDTH-1:2], 2'b00}
                                            : {addr_q[A_WIDTH-1:2], 2'b00};
    assign mem_wd    = wd_q;
    // Gated by RST so a write never lands in a reset cycle
    assign mem_we    = (state_q == ST_WRITE) && !RST;

endmodule
